// File: rtl/pipelined_barrel_shifter_if.sv
// Operand and result streams of the pipelined barrel shifter, valid/ready on both sides.
interface pipelined_barrel_shifter_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned LOG_N = 3
);
  logic [N-1:0]     in;
  logic [LOG_N-1:0] sh_sel;
  logic [2:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in, sh_sel, mode, in_valid, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in, sh_sel, mode, in_valid, out_ready,
    output in_ready, out, out_valid
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// N-bit barrel shifter, one shift-amount bit per register stage, LOG_N cycles of latency,
// with a global stall driven by the output handshake.
module pipelined_barrel_shifter #(
  parameter int unsigned N     = 8,
  parameter int unsigned LOG_N = 3
) (
  input logic clk,
  input logic rst_n,
  pipelined_barrel_shifter_if.slave bus
);

  localparam int unsigned MODE_W = 3;
  localparam logic [MODE_W-1:0] MODE_SLL = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SRL = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SRA = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ROL = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR = 3'b100;

  // Stage registers; sel_q holds the not-yet-consumed shift bits, LSB first.
  logic              valid_q [LOG_N];
  logic [N-1:0]      data_q  [LOG_N];
  logic [LOG_N-1:0]  sel_q   [LOG_N];
  logic [MODE_W-1:0] mode_q  [LOG_N];

  logic stall_c;

  assign stall_c       = valid_q[LOG_N-1] & ~bus.out_ready;
  assign bus.in_ready  = ~stall_c;
  assign bus.out       = data_q[LOG_N-1];
  assign bus.out_valid = valid_q[LOG_N-1];

  for (genvar k = 0; k < LOG_N; k++) begin : g_stage
    localparam int unsigned S = 32'd1 << k;

    logic              valid_c;
    logic [N-1:0]      d_c;
    logic [LOG_N-1:0]  sel_c;
    logic [MODE_W-1:0] mode_c;
    logic [N-1:0]      shifted_c;

    if (k == 0) begin : g_head
      assign valid_c = bus.in_valid;
      assign d_c     = bus.in;
      assign sel_c   = bus.sh_sel;
      assign mode_c  = bus.mode;
    end else begin : g_body
      assign valid_c = valid_q[k-1];
      assign d_c     = data_q[k-1];
      assign sel_c   = sel_q[k-1];
      assign mode_c  = mode_q[k-1];
    end

    // Shift by 2^k when this stage's amount bit is set; SRA fills from the incoming MSB.
    always_comb begin
      shifted_c = d_c;
      if (sel_c[0]) begin
        case (mode_c)
          MODE_SLL: shifted_c = d_c << S;
          MODE_SRL: shifted_c = d_c >> S;
          MODE_SRA: shifted_c = {{S{d_c[N-1]}}, d_c[N-1:S]};
          MODE_ROL: shifted_c = {d_c[N-1-S:0], d_c[N-1:N-S]};
          MODE_ROR: shifted_c = {d_c[S-1:0], d_c[N-1:S]};
          default:  shifted_c = d_c;
        endcase
      end
    end

    // All stages hold together on stall; bubbles advance like data.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        sel_q[k]   <= '0;
        mode_q[k]  <= '0;
      end else if (!stall_c) begin
        valid_q[k] <= valid_c;
        data_q[k]  <= shifted_c;
        sel_q[k]   <= sel_c >> 1;
        mode_q[k]  <= mode_c;
      end
    end
  end

  // Shift bits and mode leaving the final stage have no consumer.
  logic unused_tail;
  assign unused_tail = ^{sel_q[LOG_N-1], mode_q[LOG_N-1]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Randomised bench for pipelined_barrel_shifter at N=8 and N=16 against an arithmetic reference.
module tb_pipelined_barrel_shifter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [15:0] exp_q  [$];
  int          when_q [$];

  pipelined_barrel_shifter_if #(.N(8),  .LOG_N(3)) b8  ();
  pipelined_barrel_shifter_if #(.N(16), .LOG_N(4)) b16 ();

  pipelined_barrel_shifter #(.N(8), .LOG_N(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8)
  );

  pipelined_barrel_shifter #(.N(16), .LOG_N(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(b16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Whole-operand shift of width w computed with plain integer arithmetic.
  function automatic logic [15:0] ref_model(input int w, input logic [15:0] x, input int s,
                                            input logic [2:0] m);
    logic [31:0] v, mask, r;
    mask = (32'd1 << w) - 32'd1;
    v    = {16'd0, x} & mask;
    case (m)
      3'd0:    r = (v << s) & mask;
      3'd1:    r = v >> s;
      3'd2:    r = (v >> s) | (v[w-1] ? (mask & ~(mask >> s)) : 32'd0);
      3'd3:    r = ((v << s) | (v >> (w - s))) & mask;
      3'd4:    r = ((v >> s) | (v << (w - s))) & mask;
      default: r = v;
    endcase
    return r[15:0];
  endfunction

  // One clock of stimulus on the 8-bit instance; reports what the coming edge will do.
  task automatic cycle8(input logic v, input logic [7:0] d, input logic [2:0] s,
                        input logic [2:0] m, input logic ordy, output logic acc,
                        output logic xfer, output logic ov, output logic ir,
                        output logic [7:0] o);
    @(negedge clk);
    b8.in_valid  = v;
    b8.in        = d;
    b8.sh_sel    = s;
    b8.mode      = m;
    b8.out_ready = ordy;
    #1;
    ir   = b8.in_ready;
    ov   = b8.out_valid;
    o    = b8.out;
    acc  = v & ir;
    xfer = ov & ordy;
  endtask

  task automatic cycle16(input logic v, input logic [15:0] d, input logic [3:0] s,
                         input logic [2:0] m, output logic acc, output logic xfer,
                         output logic [15:0] o);
    @(negedge clk);
    b16.in_valid  = v;
    b16.in        = d;
    b16.sh_sel    = s;
    b16.mode      = m;
    b16.out_ready = 1'b1;
    #1;
    o    = b16.out;
    acc  = v & b16.in_ready;
    xfer = b16.out_valid;
  endtask

  task automatic test_reset();
    logic acc, xfer, ov, ir;
    logic [7:0] o;
    rst_n = 1'b0;
    b8.in_valid = 1'b1;  b8.in = 8'hA5;  b8.sh_sel = 3'd1;  b8.mode = 3'd0;  b8.out_ready = 1'b0;
    b16.in_valid = 1'b1; b16.in = 16'h5AA5; b16.sh_sel = 4'd2; b16.mode = 3'd1; b16.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (b8.out !== 8'h00) begin bad++; $display("FAIL reset_out: got %h want 00", b8.out); end
    total++; if (b8.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", b8.out_valid); end
    total++; if (b8.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", b8.in_ready); end
    total++; if (b16.out !== 16'h0000) begin bad++; $display("FAIL reset_out16: got %h want 0000", b16.out); end
    total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid16: got %b want 0", b16.out_valid); end
    rst_n = 1'b1;
    b8.in_valid  = 1'b0;
    b16.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle8(1'b0, 8'h00, 3'd0, 3'd0, 1'b1, acc, xfer, ov, ir, o);
      total++; if (ov !== 1'b0) begin bad++; $display("FAIL reset_quiet[%0d]: out_valid got %b want 0", c, ov); end
    end
  endtask

  task automatic test_mode_sweep();
    logic [7:0] vin [6];
    logic [2:0] vsh [6];
    logic [2:0] vmd [6];
    logic [7:0] vexp [6];
    logic acc, xfer, ov, ir;
    logic [7:0] o;
    int i, n;
    vin  = '{8'b10011101, 8'b11100101, 8'b11100101, 8'b01011011, 8'b01011011, 8'b01011011};
    vsh  = '{3'd7, 3'd1, 3'd3, 3'd3, 3'd3, 3'd5};
    vmd  = '{3'b011, 3'b000, 3'b010, 3'b001, 3'b100, 3'b111};
    vexp = '{8'b11001110, 8'b11001010, 8'b11111100, 8'b00001011, 8'b01101011, 8'b01011011};
    exp_q.delete(); when_q.delete();
    i = 0; n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      if (i < 6) cycle8(1'b1, vin[i], vsh[i], vmd[i], 1'b1, acc, xfer, ov, ir, o);
      else       cycle8(1'b0, 8'h00, 3'd0, 3'd0, 1'b1, acc, xfer, ov, ir, o);
      if (xfer) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL sweep_extra: got %b want no output", o);
        end else begin
          if (o !== exp_q[0][7:0]) begin bad++; $display("FAIL sweep_data[%0d]: got %b want %b", n, o, exp_q[0][7:0]); end
          total++;
          if (c - when_q[0] != 3) begin bad++; $display("FAIL sweep_latency[%0d]: got %0d want 3", n, c - when_q[0]); end
          void'(exp_q.pop_front()); void'(when_q.pop_front());
          n++;
        end
      end
      if (acc) begin exp_q.push_back({8'h00, vexp[i]}); when_q.push_back(c); i++; end
    end
    total++; if (n != 6) begin bad++; $display("FAIL sweep_count: got %0d want 6", n); end
  endtask

  task automatic test_throughput();
    logic [7:0] d;
    logic [2:0] s, m;
    logic [15:0] e;
    logic acc, xfer, ov, ir;
    logic [7:0] o;
    int i, n, prev;
    exp_q.delete(); when_q.delete();
    i = 0; n = 0; prev = -1;
    for (int c = 0; c < 60 && n < 16; c++) begin
      if (i < 16) begin
        d = 8'($urandom());
        s = 3'($urandom_range(0, 7));
        m = 3'($urandom_range(0, 7));
        cycle8(1'b1, d, s, m, 1'b1, acc, xfer, ov, ir, o);
        total++; if (ir !== 1'b1) begin bad++; $display("FAIL tput_in_ready[%0d]: got %b want 1", i, ir); end
      end else begin
        cycle8(1'b0, 8'h00, 3'd0, 3'd0, 1'b1, acc, xfer, ov, ir, o);
      end
      if (xfer) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL tput_extra: got %h want no output", o);
        end else begin
          if (o !== exp_q[0][7:0]) begin bad++; $display("FAIL tput_data[%0d]: got %h want %h", n, o, exp_q[0][7:0]); end
          if (prev >= 0) begin
            total++;
            if (c != prev + 1) begin bad++; $display("FAIL tput_gap[%0d]: got cycle %0d want %0d", n, c, prev + 1); end
          end
          prev = c;
          void'(exp_q.pop_front());
          n++;
        end
      end
      if (acc) begin
        e = ref_model(8, {8'h00, d}, int'(s), m);
        exp_q.push_back(e);
        i++;
      end
    end
    total++; if (n != 16) begin bad++; $display("FAIL tput_count: got %0d want 16", n); end
  endtask

  task automatic test_back_pressure();
    logic [7:0] vd [5];
    logic [2:0] vs [5];
    logic [2:0] vm [5];
    logic [15:0] e;
    logic acc, xfer, ov, ir, ordy, started;
    logic [7:0] o;
    int i, n, stall_left;
    for (int k = 0; k < 5; k++) begin
      vd[k] = 8'($urandom());
      vs[k] = 3'($urandom_range(1, 7));
      vm[k] = 3'($urandom_range(0, 4));
    end
    exp_q.delete(); when_q.delete();
    i = 0; n = 0; stall_left = 0; started = 1'b0;
    for (int c = 0; c < 60 && n < 5; c++) begin
      ordy = (stall_left == 0);
      if (i < 5) cycle8(1'b1, vd[i], vs[i], vm[i], ordy, acc, xfer, ov, ir, o);
      else       cycle8(1'b0, 8'h00, 3'd0, 3'd0, ordy, acc, xfer, ov, ir, o);
      if (!ordy) begin
        total++; if (ir !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", ir); end
        total++; if (ov !== 1'b1) begin bad++; $display("FAIL bp_out_valid: got %b want 1", ov); end
        if (exp_q.size() != 0) begin
          total++;
          if (o !== exp_q[0][7:0]) begin bad++; $display("FAIL bp_hold: got %h want %h", o, exp_q[0][7:0]); end
        end
        stall_left--;
      end
      if (xfer) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_extra: got %h want no output", o);
        end else begin
          if (o !== exp_q[0][7:0]) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", n, o, exp_q[0][7:0]); end
          void'(exp_q.pop_front());
          n++;
        end
        if (!started) begin started = 1'b1; stall_left = 4; end
      end
      if (acc) begin
        e = ref_model(8, {8'h00, vd[i]}, int'(vs[i]), vm[i]);
        exp_q.push_back(e);
        i++;
      end
    end
    total++; if (n != 5) begin bad++; $display("FAIL bp_count: got %0d want 5", n); end
    for (int c = 0; c < 4; c++) begin
      cycle8(1'b0, 8'h00, 3'd0, 3'd0, 1'b1, acc, xfer, ov, ir, o);
      total++; if (ov !== 1'b0) begin bad++; $display("FAIL bp_duplicate[%0d]: out_valid got %b want 0", c, ov); end
    end
  endtask

  task automatic test_reset_midflight();
    logic [7:0] d;
    logic [2:0] s, m;
    logic [15:0] e;
    logic acc, xfer, ov, ir;
    logic [7:0] o;
    int issued, n;
    for (int k = 0; k < 3; k++) begin
      cycle8(1'b1, 8'($urandom()), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1,
             acc, xfer, ov, ir, o);
      total++; if (ov !== 1'b0) begin bad++; $display("FAIL mid_early[%0d]: out_valid got %b want 0", k, ov); end
    end
    // The edge closing the third issue cycle is a reset edge.
    rst_n = 1'b0;
    cycle8(1'b0, 8'h00, 3'd0, 3'd0, 1'b1, acc, xfer, ov, ir, o);
    rst_n = 1'b1;
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL mid_in_reset: out_valid got %b want 0", ov); end
    for (int c = 0; c < 6; c++) begin
      cycle8(1'b0, 8'h00, 3'd0, 3'd0, 1'b1, acc, xfer, ov, ir, o);
      total++; if (ov !== 1'b0) begin bad++; $display("FAIL mid_discard[%0d]: out_valid got %b want 0", c, ov); end
    end
    d = 8'($urandom());
    s = 3'($urandom_range(1, 7));
    m = 3'($urandom_range(0, 4));
    e = ref_model(8, {8'h00, d}, int'(s), m);
    issued = -1; n = 0;
    for (int c = 0; c < 12 && n < 1; c++) begin
      if (issued < 0) cycle8(1'b1, d, s, m, 1'b1, acc, xfer, ov, ir, o);
      else            cycle8(1'b0, 8'h00, 3'd0, 3'd0, 1'b1, acc, xfer, ov, ir, o);
      if (xfer) begin
        total++; if (o !== e[7:0]) begin bad++; $display("FAIL mid_new_data: got %h want %h", o, e[7:0]); end
        total++; if (c - issued != 3) begin bad++; $display("FAIL mid_new_latency: got %0d want 3", c - issued); end
        n++;
      end
      if (acc) issued = c;
    end
    total++; if (n != 1) begin bad++; $display("FAIL mid_new_count: got %0d want 1", n); end
  endtask

  task automatic test_width16();
    logic [2:0]  vm [2];
    logic [15:0] vexp [2];
    logic acc, xfer;
    logic [15:0] o;
    int i, n;
    vm   = '{3'b010, 3'b011};
    vexp = '{16'b1111111111111111, 16'b1100000000000000};
    exp_q.delete(); when_q.delete();
    i = 0; n = 0;
    for (int c = 0; c < 20 && n < 2; c++) begin
      if (i < 2) cycle16(1'b1, 16'b1000000000000001, 4'd15, vm[i], acc, xfer, o);
      else       cycle16(1'b0, 16'h0000, 4'd0, 3'd0, acc, xfer, o);
      if (xfer) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL w16_extra: got %b want no output", o);
        end else begin
          if (o !== exp_q[0]) begin bad++; $display("FAIL w16_data[%0d]: got %b want %b", n, o, exp_q[0]); end
          total++;
          if (c - when_q[0] != 4) begin bad++; $display("FAIL w16_latency[%0d]: got %0d want 4", n, c - when_q[0]); end
          void'(exp_q.pop_front()); void'(when_q.pop_front());
          n++;
        end
      end
      if (acc) begin exp_q.push_back(vexp[i]); when_q.push_back(c); i++; end
    end
    total++; if (n != 2) begin bad++; $display("FAIL w16_count: got %0d want 2", n); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mode_sweep();
    test_throughput();
    test_back_pressure();
    test_reset_midflight();
    test_width16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
